// File: rtl/keypad_lock_pkg.sv
// Shared definitions for the keypad code lock.
//   KEY_*        : special key codes produced by the keypad scanner
//   lock_state_t : lock FSM state, encoded as seen on state_out
//   is_digit     : true for key codes 0..9
package keypad_lock_pkg;

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_BKSP  = 4'd11;
  localparam logic [3:0] KEY_PROG  = 4'd12;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROGRAM = 2'd2,
    ST_LOCKOUT = 2'd3
  } lock_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_code_lock_ms_timer.sv
// Millisecond window timer.
//   CLOCK, RST : system clock, synchronous active-high reset
//   load       : restart prescaler and load the ms down-counter with load_val
//   load_val   : window length in ms
//   expired    : high for the single cycle in which the counter reaches 0
//                after a load (not re-asserted until the next load)
module ms_timer #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        CLOCK,
  input  logic        RST,
  input  logic        load,
  input  logic [12:0] load_val,
  output logic        expired
);

  localparam int unsigned TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic [12:0]   ms_q;
  logic          armed_q;
  logic          ms_tick;

  assign ms_tick = (presc_q == PW'(TICK_DIV - 1));
  assign expired = armed_q && (ms_q == '0);

  always_ff @(posedge CLOCK) begin
    if (RST || load || ms_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // armed_q drops right after the expiry cycle so a stale window can never
  // fire twice.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      ms_q    <= '0;
      armed_q <= 1'b0;
    end else if (load) begin
      ms_q    <= load_val;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (ms_q == '0) begin
        armed_q <= 1'b0;
      end else if (ms_tick) begin
        ms_q <= ms_q - 13'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_code_lock.sv
// Digit-entry code lock fed by the 4x4 keypad scanner.
//   CLOCK, RST : system clock, synchronous active-high reset
//   key_valid  : one-cycle keypress strobe, key_code valid with it
//   key_code   : 0-9 digit, 10 Enter, 11 Backspace, 12 Program, 13-15 ignored
//   unlock     : high while OPEN
//   alarm      : high while LOCKOUT
//   err_pulse  : one-cycle pulse on a failed Enter
//   prog_done  : one-cycle pulse when a new code is stored
//   digit_buf  : entered BCD digits, newest in the low nibble
//   digit_cnt  : number of digits entered
//   state_out  : 0 ENTRY, 1 OPEN, 2 PROGRAM, 3 LOCKOUT
// All outputs are registered.
module keypad_code_lock
  import keypad_lock_pkg::*;
#(
  parameter int                DIGITS       = 4,
  parameter int                CLK_HZ       = 50_000_000,
  parameter int                OPEN_MS      = 3000,
  parameter int                LOCK_MS      = 5000,
  parameter int                MAX_TRIES    = 3,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                CLOCK,
  input  logic                RST,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                unlock,
  output logic                alarm,
  output logic                err_pulse,
  output logic                prog_done,
  output logic [4*DIGITS-1:0] digit_buf,
  output logic [2:0]          digit_cnt,
  output logic [1:0]          state_out
);

  localparam int BW = 4 * DIGITS;
  localparam int FW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  lock_state_t   state_q, state_d;
  logic [BW-1:0] code_q, code_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d;
  logic          err_d, prog_d;

  logic          tmr_load, tmr_exp;
  logic [12:0]   tmr_val;

  logic          full;
  logic          ed_hit;
  logic [BW-1:0] ed_buf;
  logic [2:0]    ed_cnt;

  ms_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .CLOCK    (CLOCK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  assign full = (cnt_q == 3'(DIGITS));

  // Digit/backspace editing shared by ENTRY and PROGRAM. ed_hit marks a
  // recognised editing key even when it leaves the buffer unchanged.
  always_comb begin
    ed_hit = 1'b0;
    ed_buf = buf_q;
    ed_cnt = cnt_q;
    if (key_valid) begin
      if (is_digit(key_code)) begin
        ed_hit = 1'b1;
        if (!full) begin
          ed_buf = (buf_q << 4) | BW'(key_code);
          ed_cnt = cnt_q + 3'd1;
        end
      end else if (key_code == KEY_BKSP) begin
        ed_hit = 1'b1;
        if (cnt_q != 3'd0) begin
          ed_buf = buf_q >> 4;
          ed_cnt = cnt_q - 3'd1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    err_d    = 1'b0;
    prog_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = 13'(OPEN_MS);

    unique case (state_q)
      ST_ENTRY: begin
        if (key_valid && key_code == KEY_ENTER) begin
          buf_d = '0;
          cnt_d = '0;
          if (full && buf_q == code_q) begin
            state_d  = ST_OPEN;
            fail_d   = '0;
            tmr_load = 1'b1;
          end else begin
            err_d = 1'b1;
            if (fail_q == FW'(MAX_TRIES - 1)) begin
              state_d  = ST_LOCKOUT;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = 13'(LOCK_MS);
            end else begin
              fail_d = fail_q + FW'(1);
            end
          end
        end else if (ed_hit) begin
          buf_d = ed_buf;
          cnt_d = ed_cnt;
        end
      end

      ST_OPEN: begin
        if (tmr_exp) begin
          state_d = ST_ENTRY;
        end else if (key_valid && key_code == KEY_PROG) begin
          state_d  = ST_PROGRAM;
          buf_d    = '0;
          cnt_d    = '0;
          tmr_load = 1'b1;
        end else if (key_valid && key_code == KEY_ENTER) begin
          state_d = ST_ENTRY;
        end
      end

      ST_PROGRAM: begin
        // A full-buffer Enter beats a coincident expiry; everything else
        // loses to it.
        if (key_valid && key_code == KEY_ENTER && full) begin
          code_d  = buf_q;
          prog_d  = 1'b1;
          state_d = ST_ENTRY;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (tmr_exp) begin
          state_d = ST_ENTRY;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (ed_hit) begin
          buf_d    = ed_buf;
          cnt_d    = ed_cnt;
          tmr_load = 1'b1;
        end
      end

      ST_LOCKOUT: begin
        buf_d = '0;
        cnt_d = '0;
        if (tmr_exp) begin
          state_d = ST_ENTRY;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q   <= ST_ENTRY;
      code_q    <= DEFAULT_CODE;
      buf_q     <= '0;
      cnt_q     <= '0;
      fail_q    <= '0;
      err_pulse <= 1'b0;
      prog_done <= 1'b0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      err_pulse <= err_d;
      prog_done <= prog_d;
      unlock    <= (state_d == ST_OPEN);
      alarm     <= (state_d == ST_LOCKOUT);
    end
  end

  assign digit_buf = buf_q;
  assign digit_cnt = cnt_q;
  assign state_out = state_q;

endmodule
